// File: rtl/vx_ctrl_pkg.sv
// Shared encodings for the vector/scalar control sequencer.
// Holds the opcode map, the sequencer state type, the datapath control
// encodings and the vector memory funct3 -> lane enable helper.
package vx_ctrl_pkg;

    localparam int LANES = 4;
    localparam int CNT_W = 2;

    // Major opcodes (inst[6:0])
    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_LW  = 7'b0000011;
    localparam logic [6:0] OPC_SW  = 7'b0100011;
    localparam logic [6:0] OPC_BR  = 7'b1100011;
    localparam logic [6:0] OPC_LUI = 7'b0110111;
    localparam logic [6:0] OPC_JAL = 7'b1101111;
    localparam logic [6:0] OPC_OPV = 7'b1010111;
    localparam logic [6:0] OPC_VLE = 7'b0000111;
    localparam logic [6:0] OPC_VSE = 7'b0100111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_VLD   = 2'd1,
        ST_VLDWB = 2'd2,
        ST_VST   = 2'd3
    } state_e;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_DMEM = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;
    localparam logic [1:0] WB_IMM  = 2'b11;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BEQ  = 2'b01;
    localparam logic [1:0] BR_BNE  = 2'b10;
    localparam logic [1:0] BR_JAL  = 2'b11;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [1:0] VOPD1_VS1  = 2'b00;
    localparam logic [1:0] VOPD1_RS1  = 2'b01;
    localparam logic [1:0] VOPD1_SIMM = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic [2:0] imm_type;
        logic [1:0] alu_op;
        logic       opd1_sel;
        logic       opd2_sel;
        logic [1:0] wb_sel;
        logic [1:0] branch;
    } x_ctrl_t;

    // Per-lane memory enable code {en, size} for a vector load/store.
    // Unsupported widths return all-zero, which the sequencer treats as illegal.
    function automatic logic [2:0] vmem_lane_code(input logic [2:0] funct3);
        case (funct3)
            3'b000:  vmem_lane_code = {1'b1, SZ_B};
            3'b101:  vmem_lane_code = {1'b1, SZ_H};
            3'b110:  vmem_lane_code = {1'b1, SZ_W};
            default: vmem_lane_code = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/vx_scalar_decode.sv
// Pure combinational decode of the scalar control fields.
// Ports:
//   opcode_i  inst[6:0]
//   funct3_i  inst[14:12] (branch flavour)
//   x_ctrl_o  scalar datapath controls, all zero for non-scalar opcodes
//   known_o   1 when opcode_i is one of the scalar opcodes
module vx_scalar_decode
    import vx_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    output x_ctrl_t    x_ctrl_o,
    output logic       known_o
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        x_ctrl_o = '0;
        known_o  = 1'b1;
        case (opcode_i)
            OPC_R: begin
                x_ctrl_o.reg_write = 1'b1;
                x_ctrl_o.alu_op    = ALU_FUNCT;
                x_ctrl_o.wb_sel    = WB_ALU;
            end
            OPC_I: begin
                x_ctrl_o.reg_write = 1'b1;
                x_ctrl_o.imm_type  = IMM_I;
                x_ctrl_o.alu_op    = ALU_FUNCT;
                x_ctrl_o.opd2_sel  = 1'b1;
            end
            OPC_LW: begin
                x_ctrl_o.reg_write = 1'b1;
                x_ctrl_o.imm_type  = IMM_I;
                x_ctrl_o.alu_op    = ALU_ADD;
                x_ctrl_o.opd2_sel  = 1'b1;
                x_ctrl_o.wb_sel    = WB_DMEM;
            end
            OPC_SW: begin
                x_ctrl_o.imm_type  = IMM_S;
                x_ctrl_o.alu_op    = ALU_ADD;
                x_ctrl_o.opd2_sel  = 1'b1;
            end
            OPC_BR: begin
                x_ctrl_o.imm_type  = IMM_B;
                x_ctrl_o.alu_op    = ALU_SUB;
                // Only beq/bne exist in the datapath; other compares do not branch.
                if (funct3_i == 3'b000) begin
                    x_ctrl_o.branch = BR_BEQ;
                end else if (funct3_i == 3'b001) begin
                    x_ctrl_o.branch = BR_BNE;
                end
            end
            OPC_LUI: begin
                x_ctrl_o.reg_write = 1'b1;
                x_ctrl_o.imm_type  = IMM_U;
                x_ctrl_o.wb_sel    = WB_IMM;
            end
            OPC_JAL: begin
                x_ctrl_o.reg_write = 1'b1;
                x_ctrl_o.imm_type  = IMM_J;
                x_ctrl_o.alu_op    = ALU_ADD;
                x_ctrl_o.opd1_sel  = 1'b1;
                x_ctrl_o.opd2_sel  = 1'b1;
                x_ctrl_o.wb_sel    = WB_PC4;
                x_ctrl_o.branch    = BR_JAL;
            end
            default: known_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/vx_ctrl_sequencer.sv
// Control stage in front of the scalar/vector datapath.
// Scalar and OP-V instructions decode in one cycle. Vector loads/stores walk
// the four 32b lanes one per cycle while the PC is stalled.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   inst                  instruction, held by fetch while pc_stall=1
//   pc_stall, VX          PC hold; vector path owns the memory port
//   xRegWrite..branch     scalar datapath controls
//   VWe0..3 / REn0..3     per-lane store / load {en, size}
//   VWBSel, VWEn          vector RF write source and per-lane enables
//   Opd1Sel, Opd2Sel      vector ALU operand selects
//   illegal               sticky unknown-instruction flag
module vx_ctrl_sequencer
    import vx_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst,
    output logic        pc_stall,
    output logic        VX,
    output logic        xRegWrite,
    output logic [2:0]  xImmType,
    output logic [1:0]  xALUOp,
    output logic        xOpd1Sel,
    output logic        xOpd2Sel,
    output logic [1:0]  xWBSel,
    output logic [1:0]  branch,
    output logic [2:0]  VWe0,
    output logic [2:0]  VWe1,
    output logic [2:0]  VWe2,
    output logic [2:0]  VWe3,
    output logic [2:0]  REn0,
    output logic [2:0]  REn1,
    output logic [2:0]  REn2,
    output logic [2:0]  REn3,
    output logic        VWBSel,
    output logic [3:0]  VWEn,
    output logic [1:0]  Opd1Sel,
    output logic [2:0]  Opd2Sel,
    output logic        illegal
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] lane_cnt_q, lane_cnt_d;
    logic             illegal_q, illegal_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [2:0] mem_code;
    logic       is_vmem, vmem_ok, decode_illegal, lane_last;
    x_ctrl_t    x_dec;
    logic       scalar_known;

    // Register indices and immediates are consumed by the datapath, not here.
    logic unused_inst_bits;
    assign unused_inst_bits = ^{inst[31:15], inst[11:7]};

    assign opcode    = inst[6:0];
    assign funct3    = inst[14:12];
    assign mem_code  = vmem_lane_code(funct3);
    assign is_vmem   = (opcode == OPC_VLE) || (opcode == OPC_VSE);
    assign vmem_ok   = is_vmem && mem_code[2];
    assign decode_illegal = !(scalar_known || (opcode == OPC_OPV) || vmem_ok);
    assign lane_last = (lane_cnt_q == CNT_W'(LANES - 1));

    vx_scalar_decode u_scalar_decode (
        .opcode_i (opcode),
        .funct3_i (funct3),
        .x_ctrl_o (x_dec),
        .known_o  (scalar_known)
    );

    logic                  stall_c, vx_c, vwbsel_c;
    logic [3:0]            vwen_c;
    logic [1:0]            vopd1_c;
    logic [LANES-1:0][2:0] ren_c, vwe_c;
    x_ctrl_t               x_c;

    always_comb begin
        state_d    = state_q;
        lane_cnt_d = lane_cnt_q;
        illegal_d  = illegal_q;
        stall_c    = 1'b0;
        vx_c       = 1'b0;
        vwbsel_c   = 1'b0;
        vwen_c     = 4'h0;
        vopd1_c    = VOPD1_VS1;
        ren_c      = '0;
        vwe_c      = '0;
        x_c        = '0;
        case (state_q)
            ST_IDLE: begin
                x_c = x_dec;
                if (opcode == OPC_OPV) begin
                    vwen_c = 4'hF;
                    case (funct3)
                        3'b100:  vopd1_c = VOPD1_RS1;
                        3'b011:  vopd1_c = VOPD1_SIMM;
                        default: vopd1_c = VOPD1_VS1;
                    endcase
                end
                // Issue cycle of a vector memory op: stall only, lanes start next cycle.
                if (vmem_ok) begin
                    stall_c    = 1'b1;
                    lane_cnt_d = '0;
                    state_d    = (opcode == OPC_VLE) ? ST_VLD : ST_VST;
                end
                if (decode_illegal) begin
                    illegal_d = 1'b1;
                end
            end
            ST_VLD: begin
                vx_c              = 1'b1;
                stall_c           = 1'b1;
                ren_c[lane_cnt_q] = mem_code;
                lane_cnt_d        = lane_cnt_q + 1'b1;
                if (lane_last) begin
                    lane_cnt_d = '0;
                    state_d    = ST_VLDWB;
                end
            end
            ST_VLDWB: begin
                vwbsel_c = 1'b1;
                vwen_c   = 4'hF;
                state_d  = ST_IDLE;
            end
            ST_VST: begin
                vx_c              = 1'b1;
                vwe_c[lane_cnt_q] = mem_code;
                // Stores need no writeback, so fetch may advance on the last lane.
                stall_c           = !lane_last;
                lane_cnt_d        = lane_cnt_q + 1'b1;
                if (lane_last) begin
                    lane_cnt_d = '0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            lane_cnt_q <= '0;
            illegal_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state_q    <= state_d;
            lane_cnt_q <= lane_cnt_d;
            illegal_q  <= illegal_d;
        end
    end

    // Outputs depend combinationally on inst, so reset must mask them directly;
    // IDLE decode would otherwise leak through while rst_n is low.
    assign pc_stall  = rst_n & stall_c;
    assign VX        = rst_n & vx_c;
    assign xRegWrite = rst_n & x_c.reg_write;
    assign xImmType  = rst_n ? x_c.imm_type : 3'b000;
    assign xALUOp    = rst_n ? x_c.alu_op   : 2'b00;
    assign xOpd1Sel  = rst_n & x_c.opd1_sel;
    assign xOpd2Sel  = rst_n & x_c.opd2_sel;
    assign xWBSel    = rst_n ? x_c.wb_sel   : 2'b00;
    assign branch    = rst_n ? x_c.branch   : 2'b00;
    assign VWe0      = rst_n ? vwe_c[0] : 3'b000;
    assign VWe1      = rst_n ? vwe_c[1] : 3'b000;
    assign VWe2      = rst_n ? vwe_c[2] : 3'b000;
    assign VWe3      = rst_n ? vwe_c[3] : 3'b000;
    assign REn0      = rst_n ? ren_c[0] : 3'b000;
    assign REn1      = rst_n ? ren_c[1] : 3'b000;
    assign REn2      = rst_n ? ren_c[2] : 3'b000;
    assign REn3      = rst_n ? ren_c[3] : 3'b000;
    assign VWBSel    = rst_n & vwbsel_c;
    assign VWEn      = rst_n ? vwen_c  : 4'h0;
    assign Opd1Sel   = rst_n ? vopd1_c : 2'b00;
    assign Opd2Sel   = 3'b000;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_vx_ctrl_sequencer.sv
`timescale 1ns/1ps
module tb_vx_ctrl_sequencer;

    // Expected/observed control word, one per clock cycle.
    typedef struct packed {
        logic        pc_stall;
        logic        vx;
        logic        x_reg_write;
        logic [2:0]  x_imm_type;
        logic [1:0]  x_alu_op;
        logic        x_opd1_sel;
        logic        x_opd2_sel;
        logic [1:0]  x_wb_sel;
        logic [1:0]  branch;
        logic [11:0] vwe;   // {lane3, lane2, lane1, lane0}
        logic [11:0] ren;
        logic        vwbsel;
        logic [3:0]  vwen;
        logic [1:0]  opd1_sel;
        logic [2:0]  opd2_sel;
        logic        illegal;
    } ctrl_t;

    localparam logic [31:0] ADD_X3   = 32'h002081B3;
    localparam logic [31:0] VLE32_V1 = 32'h0202E087;
    localparam logic [31:0] VSE8_V2  = 32'h02030127;
    localparam logic [31:0] ALL_ONES = 32'hFFFFFFFF;
    localparam logic [31:0] VADD_VX  = 32'h0220C0D7;

    logic        clk, rst_n;
    logic [31:0] inst;
    logic        pc_stall, VX, xRegWrite, xOpd1Sel, xOpd2Sel, VWBSel, illegal;
    logic [2:0]  xImmType, VWe0, VWe1, VWe2, VWe3, REn0, REn1, REn2, REn3, Opd2Sel;
    logic [1:0]  xALUOp, xWBSel, branch, Opd1Sel;
    logic [3:0]  VWEn;

    vx_ctrl_sequencer dut (
        .clk(clk), .rst_n(rst_n), .inst(inst),
        .pc_stall(pc_stall), .VX(VX), .xRegWrite(xRegWrite), .xImmType(xImmType),
        .xALUOp(xALUOp), .xOpd1Sel(xOpd1Sel), .xOpd2Sel(xOpd2Sel), .xWBSel(xWBSel),
        .branch(branch), .VWe0(VWe0), .VWe1(VWe1), .VWe2(VWe2), .VWe3(VWe3),
        .REn0(REn0), .REn1(REn1), .REn2(REn2), .REn3(REn3), .VWBSel(VWBSel),
        .VWEn(VWEn), .Opd1Sel(Opd1Sel), .Opd2Sel(Opd2Sel), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_fail   = 0;
    bit    m_illegal = 1'b0;
    ctrl_t exp_q[$];
    string tag_q[$];

    task automatic check(input string name, input ctrl_t act, input ctrl_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic ctrl_t sample();
        return {pc_stall, VX, xRegWrite, xImmType, xALUOp, xOpd1Sel, xOpd2Sel, xWBSel,
                branch, VWe3, VWe2, VWe1, VWe0, REn3, REn2, REn1, REn0, VWBSel, VWEn,
                Opd1Sel, Opd2Sel, illegal};
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [2:0] lane_code(input logic [2:0] f3);
        if (f3 == 3'b000) return 3'b100;
        if (f3 == 3'b101) return 3'b101;
        if (f3 == 3'b110) return 3'b110;
        return 3'b000;
    endfunction

    function automatic bit is_vmem_ok(input logic [31:0] in);
        return (in[6:0] == 7'b0000111 || in[6:0] == 7'b0100111) && lane_code(in[14:12])[2];
    endfunction

    function automatic bit is_unknown(input logic [31:0] in);
        case (in[6:0])
            7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b0110111, 7'b1101111, 7'b1010111: return 1'b0;
            default: return !is_vmem_ok(in);
        endcase
    endfunction

    // Cycles an instruction occupies: vector load = issue + 4 lanes + writeback,
    // vector store = issue + 4 lanes, everything else one cycle.
    function automatic int seq_len(input logic [31:0] in);
        if (!is_vmem_ok(in)) return 1;
        return (in[6:0] == 7'b0000111) ? 6 : 5;
    endfunction

    // Expected outputs during cycle 'phase' of instruction 'in'.
    function automatic ctrl_t model(input logic [31:0] in, input int phase, input bit ill);
        ctrl_t      e;
        logic [2:0] f3;
        logic [2:0] lc;
        e  = '0;
        f3 = in[14:12];
        lc = lane_code(f3);
        e.illegal = ill;
        case (in[6:0])
            7'b0110011: begin e.x_reg_write = 1; e.x_alu_op = 2'b10; end
            7'b0010011: begin e.x_reg_write = 1; e.x_alu_op = 2'b10; e.x_opd2_sel = 1; end
            7'b0000011: begin e.x_reg_write = 1; e.x_opd2_sel = 1; e.x_wb_sel = 2'b01; end
            7'b0100011: begin e.x_imm_type = 3'b001; e.x_opd2_sel = 1; end
            7'b1100011: begin
                e.x_imm_type = 3'b010;
                e.x_alu_op   = 2'b01;
                e.branch     = (f3 == 3'b000) ? 2'b01 : (f3 == 3'b001) ? 2'b10 : 2'b00;
            end
            7'b0110111: begin e.x_reg_write = 1; e.x_imm_type = 3'b011; e.x_wb_sel = 2'b11; end
            7'b1101111: begin
                e.x_reg_write = 1; e.x_imm_type = 3'b100; e.x_opd1_sel = 1;
                e.x_opd2_sel = 1; e.x_wb_sel = 2'b10; e.branch = 2'b11;
            end
            7'b1010111: begin
                e.vwen     = 4'hF;
                e.opd1_sel = (f3 == 3'b100) ? 2'b01 : (f3 == 3'b011) ? 2'b10 : 2'b00;
            end
            7'b0000111: if (lc[2]) begin
                if (phase == 0) begin
                    e.pc_stall = 1;
                end else if (phase <= 4) begin
                    e.pc_stall = 1;
                    e.vx       = 1;
                    e.ren[(phase-1)*3 +: 3] = lc;
                end else begin
                    e.vwbsel = 1;
                    e.vwen   = 4'hF;
                end
            end
            7'b0100111: if (lc[2]) begin
                if (phase == 0) begin
                    e.pc_stall = 1;
                end else begin
                    e.pc_stall = (phase != 4);
                    e.vx       = 1;
                    e.vwe[(phase-1)*3 +: 3] = lc;
                end
            end
            default: ;
        endcase
        return e;
    endfunction

    // ---------------- stimulus ----------------
    task automatic drive(input logic [31:0] in, input string tag, input bit release_rst);
        int n;
        n = seq_len(in);
        for (int p = 0; p < n; p++) begin
            @(posedge clk);
            #1;
            inst = in;
            if (release_rst) rst_n = 1'b1;
            exp_q.push_back(model(in, p, m_illegal));
            tag_q.push_back(tag);
        end
        if (is_unknown(in)) m_illegal = 1'b1;
    endtask

    task automatic reset_cycle();
        @(posedge clk);
        #1;
        exp_q.push_back(ctrl_t'(0));
        tag_q.push_back("in_reset");
    endtask

    // VLE up to and including lane 2, then an asynchronous reset pulse.
    task automatic reset_mid_vld();
        for (int p = 0; p < 4; p++) begin
            @(posedge clk);
            #1;
            inst = VLE32_V1;
            exp_q.push_back(model(VLE32_V1, p, m_illegal));
            tag_q.push_back("vle_pre_reset");
        end
        @(negedge clk);
        #1;
        rst_n     = 1'b0;
        m_illegal = 1'b0;
        #1;
        check("reset_async_zero", sample(), ctrl_t'(0));
        reset_cycle();
        reset_cycle();
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        logic [6:0]  ops [10];
        int          k;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b0110111, 7'b1101111, 7'b1010111, 7'b0000111, 7'b0100111};
        r = $urandom;
        k = $urandom_range(0, 12);
        if (k < 10) r[6:0] = ops[k];
        else if (k == 10) r[6:0] = ops[8];
        if ((r[6:0] == 7'b0000111 || r[6:0] == 7'b0100111) && ($urandom_range(0, 3) != 0)) begin
            k = $urandom_range(0, 2);
            r[14:12] = (k == 0) ? 3'b000 : (k == 1) ? 3'b101 : 3'b110;
        end
        return r;
    endfunction

    // ---------------- monitor ----------------
    initial begin
        forever begin
            ctrl_t e;
            string t;
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                check(t, sample(), e);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        inst  = VLE32_V1;
        #2;
        check("reset_zero_with_vle", sample(), ctrl_t'(0));
        reset_cycle();
        reset_cycle();
        drive(VLE32_V1, "vle32_after_release", 1'b1);
        drive(ADD_X3,   "add_x3", 1'b0);
        drive(VSE8_V2,  "vse8", 1'b0);
        drive(VADD_VX,  "vadd_vx", 1'b0);
        drive(ADD_X3,   "add_after_vse", 1'b0);

        reset_mid_vld();
        drive(ADD_X3,   "add_after_mid_reset", 1'b1);
        drive(VLE32_V1, "vle_lane0_restart", 1'b0);

        drive(ALL_ONES, "illegal_ones", 1'b0);
        drive(ADD_X3,   "illegal_sticky_add", 1'b0);
        drive(VSE8_V2,  "illegal_sticky_vse", 1'b0);

        for (int i = 0; i < 250; i++) begin
            drive(rand_inst(), "random", 1'b0);
        end

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected cycles unchecked, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
